hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
- Multi-cycle multiply/divide unit in the EX stage that owns the architectural HI and LO registers.
- Executes MULT, MULTU, DIV and DIVU.
- Accepts MTHI and MTLO writes.
- Supplies the HI/LO value for MFHI/MFLO. That value travels down the pipe as the mf_hi_lo result selected at writeback.
- Stalls the pipeline when an access collides with an in-flight operation.

Parameters:
- MUL_CYCLES, 4, cycles busy stays high for a multiply (legal range 1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active high.
- start  input  1  issue a mul/div in this cycle.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  32  rs operand (dividend / multiplicand).
- b  input  32  rt operand (divisor / multiplier).
- mf_req  input  1  MFHI/MFLO in EX this cycle.
- hilo_sel  input  1  0 = LO, 1 = HI (read select for mf_req).
- we_hi  input  1  MTHI write.
- we_lo  input  1  MTLO write.
- wd  input  32  MTHI/MTLO data.
- rd_hilo  output  32  combinational: hilo_sel ? hi : lo.
- hi  output  32  HI register.
- lo  output  32  LO register.
- busy  output  1  operation in flight.
- stall  output  1  freeze IF/ID/EX this cycle.
- dbz  output  1  one-cycle pulse: divide by zero completed.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, hi=0, lo=0, busy=0, dbz=0, counter=0.
  - Reset mid-operation aborts the operation. No HI/LO update occurs.
- States: IDLE, MUL, DIV. busy = (state != IDLE), registered.
- IDLE:
  - With start=1, latch a, b and op.
  - op[1]=0: load counter with MUL_CYCLES and go to MUL.
  - op[1]=1: load counter with 33 and go to DIV.
  - start has priority over we_hi/we_lo in the same cycle. The MT write is dropped (the decoder never issues both).
  - Without start: we_hi writes hi<=wd and we_lo writes lo<=wd. Both may be set together.
- MUL:
  - Counter decrements every cycle.
  - On the cycle counter==1: {hi,lo} <= 64-bit product, then go to IDLE.
  - MULTU is an unsigned 32x32 multiply. MULT is a two's-complement 32x32 multiply with a full 64-bit signed result.
  - busy is high for exactly MUL_CYCLES cycles.
- DIV:
  - Cycles 1..32: restoring division on magnitudes, one quotient bit per cycle.
  - For DIV, magnitudes are |a| and |b|. For DIVU, magnitudes are the raw values.
  - Cycle 33 (sign fix-up):
    - lo <= quotient, negated if op=DIV and a[31]^b[31].
    - hi <= remainder, negated if op=DIV and a[31].
    - Then go to IDLE.
  - busy is high for exactly 33 cycles.
  - Divide by zero (b==0, latched):
    - Runs the full 33 cycles. hi and lo are left unchanged.
    - dbz=1 for the cycle after completion.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No flag.
- HI/LO results are visible on hi/lo/rd_hilo in the first cycle busy=0.
- stall = busy & (start | mf_req | we_hi | we_lo), combinational.
  - While stalled, the EX instruction is held and re-presented.
  - start, mf_req, we_hi and we_lo are ignored while busy. They take effect on the first non-busy cycle.
  - busy with no access pending: stall=0. Independent instructions keep flowing.
- rd_hilo reads current registers only. There is no bypass of a same-cycle we_hi/we_lo. The decoder never places an MT and MF back-to-back without the pipeline's existing forwarding.
- Counter width: 6 bits.

Test Plan:
- MULTU a=0xFFFFFFFF b=2, MUL_CYCLES=4 -> busy high 4 cycles; then hi=0x00000001, lo=0xFFFFFFFE.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Also DIV a=-7 b=2 -> busy 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=7 -> lo=14, hi=2. Then mf_req=1, hilo_sel=1 -> rd_hilo=2.
- mf_req=1 asserted 3 cycles after a DIVU start -> stall=1 until busy falls. rd_hilo shows the new LO in the first cycle stall=0. A second start during busy is ignored, and busy does not extend.
- we_hi=1 with wd=0x12345678 in IDLE, then DIV b=0 -> hi stays 0x12345678 and lo unchanged; dbz pulses exactly 1 cycle after busy falls.
- rst=1 at cycle 10 of a DIV -> next cycle busy=0, hi=lo=0, dbz=0. A following MULTU 6*7 gives lo=42, hi=0.

Source files
------------

// File: rtl/hilo_muldiv.sv
// HI/LO register owner with a multi-cycle multiplier and a restoring divider.
// Multiplies take MUL_CYCLES cycles, divides take 33 cycles (32 steps plus a sign fix-up).
module hilo_muldiv #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mf_req,
  input  logic        hilo_sel,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] wd,
  output logic [31:0] rd_hilo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        dbz
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  localparam logic [5:0] MulCnt = 6'(MUL_CYCLES);
  localparam logic [5:0] DivCnt = 6'd33;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d;
  logic        dbz_q, dbz_d;

  logic [63:0] mul_a, mul_b, product;
  logic        neg_a, neg_b;
  logic [31:0] mag_b, quo_fix, rem_fix;
  logic [32:0] shifted, diff;

  // op[0] marks the signed variants of both multiply and divide.
  assign neg_a   = op_q[0] & a_q[31];
  assign neg_b   = op_q[0] & b_q[31];
  assign mul_a   = {{32{neg_a}}, a_q};
  assign mul_b   = {{32{neg_b}}, b_q};
  assign product = mul_a * mul_b;

  assign mag_b   = neg_b ? -b_q : b_q;
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, mag_b};
  assign quo_fix = (neg_a ^ neg_b) ? -quo_q : quo_q;
  assign rem_fix = neg_a ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dbz_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          op_d  = op;
          rem_d = '0;
          // The dividend register shifts out one bit per step and fills with quotient bits.
          quo_d = (op[0] & a[31]) ? -a : a;
          if (op[1]) begin
            cnt_d   = DivCnt;
            state_d = StDiv;
          end else begin
            cnt_d   = MulCnt;
            state_d = StMul;
          end
        end else begin
          if (we_hi) hi_d = wd;
          if (we_lo) lo_d = wd;
        end
      end
      StMul: begin
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          {hi_d, lo_d} = product;
          state_d      = StIdle;
        end
      end
      StDiv: begin
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d = StIdle;
          if (b_q == '0) begin
            dbz_d = 1'b1;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign stall   = busy & (start | mf_req | we_hi | we_lo);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign dbz     = dbz_q;
  assign rd_hilo = hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: a reference model pushes expected HI/LO/dbz/latency
// per operation; each scenario task pops and compares when busy falls.
module tb_hilo_muldiv;

  localparam int unsigned MulCycles = 4;

  logic        clk = 1'b0;
  logic        rst, start, mf_req, hilo_sel, we_hi, we_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wd;
  logic [31:0] rd_hilo, hi, lo;
  logic        busy, stall, dbz;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cycles;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl_hi, mdl_lo;
  int          checks = 0;
  int          errors = 0;

  hilo_muldiv #(.MUL_CYCLES(MulCycles)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mf_req(mf_req), .hilo_sel(hilo_sel), .we_hi(we_hi), .we_lo(we_lo), .wd(wd),
    .rd_hilo(rd_hilo), .hi(hi), .lo(lo), .busy(busy), .stall(stall), .dbz(dbz)
  );

  always #5 clk = ~clk;

  // Reference model built on native arithmetic; divides use 64-bit signed math to avoid overflow.
  task automatic model_push(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    e.dbz = 1'b0;
    if (!o[1]) begin
      e.cycles = MulCycles;
      if (o[0]) begin
        q = sx * sy;
        p = q;
      end else begin
        p = {32'b0, x} * {32'b0, y};
      end
      mdl_hi = p[63:32];
      mdl_lo = p[31:0];
    end else begin
      e.cycles = 33;
      if (y == 32'd0) begin
        e.dbz = 1'b1;
      end else if (o[0]) begin
        q      = sx / sy;
        r      = sx % sy;
        mdl_lo = q[31:0];
        mdl_hi = r[31:0];
      end else begin
        mdl_lo = x / y;
        mdl_hi = x % y;
      end
    end
    e.hi = mdl_hi;
    e.lo = mdl_lo;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge of the first non-busy cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int cyc, output int early_dbz);
    model_push(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk) #1;
    start = 1'b0;
    cyc = 0;
    early_dbz = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (dbz) early_dbz++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    checks++; if ({busy, stall, dbz} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {busy, stall, dbz});
    end
    rst = 1'b0;
    mdl_hi = '0;
    mdl_lo = '0;
    @(negedge clk);
  endtask

  task automatic test_multu();
    int cyc, ed; exp_t e;
    do_op(2'b00, 32'hFFFF_FFFF, 32'd2, cyc, ed);
    e = sb_q.pop_front();
    checks++; if (cyc !== e.cycles) begin errors++; $display("FAIL multu_busy got %0d want %0d", cyc, e.cycles); end
    checks++; if (hi !== 32'h1) begin errors++; $display("FAIL multu_hi got %h want 00000001", hi); end
    checks++; if (lo !== e.lo) begin errors++; $display("FAIL multu_lo got %h want %h", lo, e.lo); end
  endtask

  task automatic test_mult();
    int cyc, ed; exp_t e;
    do_op(2'b01, 32'hFFFF_FFFD, 32'd5, cyc, ed);
    e = sb_q.pop_front();
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    checks++; if (lo !== e.lo) begin errors++; $display("FAIL mult_lo got %h want %h", lo, e.lo); end
  endtask

  task automatic test_div_signed();
    int cyc, ed; exp_t e;
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, cyc, ed);
    e = sb_q.pop_front();
    checks++; if (cyc !== 33) begin errors++; $display("FAIL div_busy got %0d want 33", cyc); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
    checks++; if (hi !== e.hi) begin errors++; $display("FAIL div_hi got %h want %h", hi, e.hi); end
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, cyc, ed);
    e = sb_q.pop_front();
    checks++; if ({hi, lo, dbz} !== {e.hi, e.lo, 1'b0}) begin
      errors++; $display("FAIL div_ovf got %h/%h/%b want %h/%h/0", hi, lo, dbz, e.hi, e.lo);
    end
  endtask

  task automatic test_divu_mf();
    int cyc, ed; exp_t e;
    do_op(2'b10, 32'd100, 32'd7, cyc, ed);
    e = sb_q.pop_front();
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %0d want 14", lo); end
    mf_req = 1'b1; hilo_sel = 1'b1;
    #1;
    checks++; if (rd_hilo !== e.hi) begin errors++; $display("FAIL mfhi got %h want %h", rd_hilo, e.hi); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mf_idle_stall got %b want 0", stall); end
    hilo_sel = 1'b0;
    #1;
    checks++; if (rd_hilo !== e.lo) begin errors++; $display("FAIL mflo got %h want %h", rd_hilo, e.lo); end
    mf_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stall();
    int cnt, bad; exp_t e;
    model_push(2'b10, 32'd1000, 32'd9);
    e = sb_q.pop_front();
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd9; hilo_sel = 1'b0;
    cnt = 0; bad = 0;
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (stall !== (start | mf_req)) bad++;
      start = (k == 3);
      if (k == 3) begin op = 2'b00; a = 32'd5; b = 32'd1; end
      mf_req = (k >= 3);
    end
    checks++; if (cnt !== 33) begin errors++; $display("FAIL stall_busy_len got %0d want 33", cnt); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_during_busy got %0d bad want 0", bad); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_release got %b want 0", stall); end
    checks++; if (rd_hilo !== e.lo) begin errors++; $display("FAIL stall_rd got %h want %h", rd_hilo, e.lo); end
    mf_req = 1'b0;
    @(negedge clk);
    checks++; if ({busy, lo} !== {1'b0, e.lo}) begin
      errors++; $display("FAIL ignored_start got %b/%h want 0/%h", busy, lo, e.lo);
    end
  endtask

  task automatic test_mt();
    int cyc, ed; exp_t e;
    we_hi = 1'b1; we_lo = 1'b1; wd = 32'hA5A5_F00F;
    @(negedge clk);
    we_hi = 1'b0; we_lo = 1'b0;
    mdl_hi = 32'hA5A5_F00F; mdl_lo = 32'hA5A5_F00F;
    checks++; if ({hi, lo} !== {mdl_hi, mdl_lo}) begin
      errors++; $display("FAIL mt_both got %h/%h want %h/%h", hi, lo, mdl_hi, mdl_lo);
    end
    we_lo = 1'b1; wd = 32'hDEAD_BEEF;
    do_op(2'b00, 32'd3, 32'd4, cyc, ed);
    e = sb_q.pop_front();
    checks++; if (lo !== e.lo) begin errors++; $display("FAIL mt_dropped got %h want %h", lo, e.lo); end
    we_lo = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dbz();
    int cyc, ed; exp_t e;
    we_hi = 1'b1; wd = 32'h1234_5678;
    @(negedge clk);
    we_hi = 1'b0;
    mdl_hi = 32'h1234_5678;
    do_op(2'b11, 32'd55, 32'd0, cyc, ed);
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== {e.hi, e.lo}) begin
      errors++; $display("FAIL dbz_keep got %h/%h want %h/%h", hi, lo, e.hi, e.lo);
    end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL dbz_busy got %0d want 33", cyc); end
    checks++; if ({ed, dbz} !== {32'd0, e.dbz}) begin
      errors++; $display("FAIL dbz_pulse got early=%0d now=%b want 0/1", ed, dbz);
    end
    @(negedge clk);
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL dbz_width got %b want 0", dbz); end
  endtask

  task automatic test_reset_mid();
    int cyc, ed; exp_t e;
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_hi = '0; mdl_lo = '0;
    checks++; if ({busy, dbz, hi, lo} !== 66'd0) begin
      errors++; $display("FAIL rst_mid got busy=%b dbz=%b hi=%h lo=%h want 0", busy, dbz, hi, lo);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_abort got %b want 0", busy); end
    do_op(2'b00, 32'd6, 32'd7, cyc, ed);
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== {32'd0, 32'd42}) begin
      errors++; $display("FAIL rst_then_mul got %h/%h want 0/2a", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, ed; exp_t e;
    logic [1:0] o; logic [31:0] x, y;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if (i % 2 == 1) y = y >> 20;
      if (i == 5) y = 32'd0;
      do_op(o, x, y, cyc, ed);
      e = sb_q.pop_front();
      checks++; if ({hi, lo, dbz} !== {e.hi, e.lo, e.dbz} || cyc !== e.cycles) begin
        errors++;
        $display("FAIL b2b_%0d op=%0d a=%h b=%h got %h/%h/%b/%0d want %h/%h/%b/%0d", i, o, x, y,
                 hi, lo, dbz, cyc, e.hi, e.lo, e.dbz, e.cycles);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    mf_req = 1'b0; hilo_sel = 1'b0; we_hi = 1'b0; we_lo = 1'b0; wd = '0;
    @(negedge clk);
    test_reset();
    test_multu();
    test_mult();
    test_div_signed();
    test_divu_mf();
    test_stall();
    test_mt();
    test_dbz();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
